// File: rtl/serv_alu_stream_if.sv
// rtl/serv_alu_stream_if.sv - operand request / result response handshake bundle
interface serv_alu_stream_if #(
   parameter int XLEN = 32
);
   logic            i_req_valid;
   logic            o_req_ready;
   logic [XLEN-1:0] i_rs1;
   logic [XLEN-1:0] i_op_b;
   logic            o_rsp_valid;
   logic            i_rsp_ready;
   logic [XLEN-1:0] o_result;
   logic            o_cmp;

   modport master (
      output i_req_valid, i_rs1, i_op_b, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_result, o_cmp
   );

   modport slave (
      input  i_req_valid, i_rs1, i_op_b, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_result, o_cmp
   );
endinterface

// File: rtl/serv_alu_stream.sv
// rtl/serv_alu_stream.sv - serialises operand pairs into the bit-serial ALU and reassembles the result
module serv_alu_stream #(
   parameter int XLEN = 32,
   parameter int W    = 1
) (
   input  logic                clk,
   input  logic                i_rst,
   serv_alu_stream_if.slave    bus,
   output logic                o_alu_en,
   output logic                o_alu_cnt0,
   output logic [W-1:0]        o_alu_rs1,
   output logic [W-1:0]        o_alu_op_b,
   input  logic [W-1:0]        i_alu_rd,
   input  logic                i_alu_cmp
);
   localparam int N  = XLEN / W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rs1_q, rs1_d;
   logic [XLEN-1:0] op_b_q, op_b_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            cmp_q, cmp_d;
   logic [XLEN+W-1:0] result_cat;

   // Newest slice enters at the top; after N slices the first one sits at bits [W-1:0].
   assign result_cat = {i_alu_rd, result_q} >> W;

   assign bus.o_result = result_q;
   assign bus.o_cmp    = cmp_q;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rs1_q    <= '0;
         op_b_q   <= '0;
         result_q <= '0;
         cmp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rs1_q    <= rs1_d;
         op_b_q   <= op_b_d;
         result_q <= result_d;
         cmp_q    <= cmp_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      rs1_d           = rs1_q;
      op_b_d          = op_b_q;
      result_d        = result_q;
      cmp_d           = cmp_q;
      bus.o_req_ready = 1'b0;
      bus.o_rsp_valid = 1'b0;
      o_alu_en        = 1'b0;
      o_alu_cnt0      = 1'b0;
      o_alu_rs1       = '0;
      o_alu_op_b      = '0;
      case (state_q)
         IDLE: begin
            // ALU enable stays low here so the ALU presets its carry before the next run.
            bus.o_req_ready = 1'b1;
            if (bus.i_req_valid) begin
               rs1_d   = bus.i_rs1;
               op_b_d  = bus.i_op_b;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            o_alu_en   = 1'b1;
            o_alu_cnt0 = (cnt_q == '0);
            o_alu_rs1  = rs1_q[W-1:0];
            o_alu_op_b = op_b_q[W-1:0];
            rs1_d      = rs1_q >> W;
            op_b_d     = op_b_q >> W;
            result_d   = result_cat[XLEN-1:0];
            cnt_d      = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cmp_d   = i_alu_cmp;
               state_d = DONE;
            end
         end
         DONE: begin
            bus.o_rsp_valid = 1'b1;
            if (bus.i_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_serv_alu_stream.sv
// tb/tb_serv_alu_stream.sv - directed bench for serv_alu_stream at W=1, W=4 and W=32
module tb_serv_alu_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic        req_valid [3];
   logic        req_ready [3];
   logic [31:0] rs1_v     [3];
   logic [31:0] op_b_v    [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] result_o  [3];
   logic        cmp_o     [3];
   logic        alu_en    [3];
   logic        alu_cnt0  [3];
   logic        alu_sub;
   logic        alu_eq;

   serv_alu_stream_if #(.XLEN(32)) bus0 (), bus1 (), bus2 ();

   assign bus0.i_req_valid = req_valid[0];
   assign bus0.i_rs1       = rs1_v[0];
   assign bus0.i_op_b      = op_b_v[0];
   assign bus0.i_rsp_ready = rsp_ready[0];
   assign req_ready[0]     = bus0.o_req_ready;
   assign rsp_valid[0]     = bus0.o_rsp_valid;
   assign result_o[0]      = bus0.o_result;
   assign cmp_o[0]         = bus0.o_cmp;

   assign bus1.i_req_valid = req_valid[1];
   assign bus1.i_rs1       = rs1_v[1];
   assign bus1.i_op_b      = op_b_v[1];
   assign bus1.i_rsp_ready = rsp_ready[1];
   assign req_ready[1]     = bus1.o_req_ready;
   assign rsp_valid[1]     = bus1.o_rsp_valid;
   assign result_o[1]      = bus1.o_result;
   assign cmp_o[1]         = bus1.o_cmp;

   assign bus2.i_req_valid = req_valid[2];
   assign bus2.i_rs1       = rs1_v[2];
   assign bus2.i_op_b      = op_b_v[2];
   assign bus2.i_rsp_ready = rsp_ready[2];
   assign req_ready[2]     = bus2.o_req_ready;
   assign rsp_valid[2]     = bus2.o_rsp_valid;
   assign result_o[2]      = bus2.o_result;
   assign cmp_o[2]         = bus2.o_cmp;

   // Behavioural serial ALU per width: carry preset to alu_sub while disabled,
   // signed-lt from the final slice, equality accumulated across slices.
   logic [0:0]  a1, b1, rd1;
   logic [1:0]  s1;
   logic        c1_q, eq1_q, eqn1, cmp1;
   always_comb begin
      s1   = {1'b0, a1} + {1'b0, b1 ^ {1{alu_sub}}} + 2'(c1_q);
      rd1  = s1[0:0];
      eqn1 = (a1 == b1) && (alu_cnt0[0] || eq1_q);
      cmp1 = alu_eq ? eqn1 : ((a1[0] != b1[0]) ? a1[0] : s1[0]);
   end
   always @(posedge clk) begin
      c1_q  <= alu_en[0] ? s1[1] : alu_sub;
      eq1_q <= alu_en[0] ? eqn1 : 1'b1;
   end

   logic [3:0]  a4, b4, rd4;
   logic [4:0]  s4;
   logic        c4_q, eq4_q, eqn4, cmp4;
   always_comb begin
      s4   = {1'b0, a4} + {1'b0, b4 ^ {4{alu_sub}}} + 5'(c4_q);
      rd4  = s4[3:0];
      eqn4 = (a4 == b4) && (alu_cnt0[1] || eq4_q);
      cmp4 = alu_eq ? eqn4 : ((a4[3] != b4[3]) ? a4[3] : s4[3]);
   end
   always @(posedge clk) begin
      c4_q  <= alu_en[1] ? s4[4] : alu_sub;
      eq4_q <= alu_en[1] ? eqn4 : 1'b1;
   end

   logic [31:0] a32, b32, rd32;
   logic [32:0] s32;
   logic        c32_q, eq32_q, eqn32, cmp32;
   always_comb begin
      s32   = {1'b0, a32} + {1'b0, b32 ^ {32{alu_sub}}} + 33'(c32_q);
      rd32  = s32[31:0];
      eqn32 = (a32 == b32) && (alu_cnt0[2] || eq32_q);
      cmp32 = alu_eq ? eqn32 : ((a32[31] != b32[31]) ? a32[31] : s32[31]);
   end
   always @(posedge clk) begin
      c32_q  <= alu_en[2] ? s32[32] : alu_sub;
      eq32_q <= alu_en[2] ? eqn32 : 1'b1;
   end

   serv_alu_stream #(.XLEN(32), .W(1)) u_w1 (
      .clk        (clk),
      .i_rst      (rst),
      .bus        (bus0),
      .o_alu_en   (alu_en[0]),
      .o_alu_cnt0 (alu_cnt0[0]),
      .o_alu_rs1  (a1),
      .o_alu_op_b (b1),
      .i_alu_rd   (rd1),
      .i_alu_cmp  (cmp1)
   );

   serv_alu_stream #(.XLEN(32), .W(4)) u_w4 (
      .clk        (clk),
      .i_rst      (rst),
      .bus        (bus1),
      .o_alu_en   (alu_en[1]),
      .o_alu_cnt0 (alu_cnt0[1]),
      .o_alu_rs1  (a4),
      .o_alu_op_b (b4),
      .i_alu_rd   (rd4),
      .i_alu_cmp  (cmp4)
   );

   serv_alu_stream #(.XLEN(32), .W(32)) u_w32 (
      .clk        (clk),
      .i_rst      (rst),
      .bus        (bus2),
      .o_alu_en   (alu_en[2]),
      .o_alu_cnt0 (alu_cnt0[2]),
      .o_alu_rs1  (a32),
      .o_alu_op_b (b32),
      .i_alu_rd   (rd32),
      .i_alu_cmp  (cmp32)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One operation on instance sel; lat counts negedges from accept until rsp_valid.
   task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_cmp,
                        input int n, input int hold);
      int lat, en_cnt, c0_cnt, busy_bad, bp_bad;
      @(negedge clk);
      check("req_ready_idle", req_ready[sel], 1'b1);
      req_valid[sel] = 1'b1;
      rs1_v[sel]     = a;
      op_b_v[sel]    = b;
      @(negedge clk);
      req_valid[sel] = 1'b0;
      lat = 1; en_cnt = 0; c0_cnt = 0; busy_bad = 0;
      while (!rsp_valid[sel] && lat < 200) begin
         en_cnt += int'(alu_en[sel]);
         c0_cnt += int'(alu_cnt0[sel]);
         if (req_ready[sel]) busy_bad++;
         @(negedge clk);
         lat++;
      end
      check("latency", lat, n + 1);
      check("alu_en_cycles", en_cnt, n);
      check("cnt0_cycles", c0_cnt, 1);
      check("req_ready_busy", busy_bad, 0);
      check("result", result_o[sel], exp_res);
      check("cmp", cmp_o[sel], exp_cmp);
      if (hold > 0) begin
         bp_bad = 0;
         req_valid[sel] = 1'b1;
         rs1_v[sel]     = 32'hDEAD_BEEF;
         repeat (hold) begin
            @(negedge clk);
            if (result_o[sel] !== exp_res || cmp_o[sel] !== exp_cmp || rsp_valid[sel] !== 1'b1
                || req_ready[sel] !== 1'b0 || alu_en[sel] !== 1'b0)
               bp_bad++;
         end
         req_valid[sel] = 1'b0;
         check("backpressure", bp_bad, 0);
      end
      rsp_ready[sel] = 1'b1;
      @(negedge clk);
      rsp_ready[sel] = 1'b0;
      check("rsp_valid_clear", rsp_valid[sel], 1'b0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      alu_sub = 1'b0;
      alu_eq  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = 1'b0;
         rs1_v[i]     = '0;
         op_b_v[i]    = '0;
         rsp_ready[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready[0], 1'b1);
      check("rst_rsp_valid", rsp_valid[0], 1'b0);
      check("rst_alu_en", alu_en[0], 1'b0);
      check("rst_alu_cnt0", alu_cnt0[0], 1'b0);
      check("rst_alu_rs1", a1, 1'b0);
      check("rst_result", result_o[0], 32'h0);
      check("rst_cmp", cmp_o[0], 1'b0);
      check("rst_alu_op_b_w32", b32, 32'h0);
      rst = 1'b0;

      alu_sub = 1'b0; alu_eq = 1'b0;
      do_op(0, 32'd5, 32'd7, 32'd12, 1'b0, 32, 0);
      alu_sub = 1'b1;
      do_op(0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 32, 10);
      do_op(0, 32'd5, 32'd3, 32'd2, 1'b0, 32, 0);

      alu_sub = 1'b1; alu_eq = 1'b1;
      do_op(1, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 8, 0);
      do_op(1, 32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b0, 8, 0);

      alu_sub = 1'b0; alu_eq = 1'b0;
      do_op(2, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1, 0);

      // Reset in the middle of a run with the request still asserted.
      @(negedge clk);
      req_valid[0] = 1'b1;
      rs1_v[0]     = 32'd5;
      op_b_v[0]    = 32'd7;
      repeat (10) @(negedge clk);
      check("run_before_rst", alu_en[0], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_run_rsp_valid", rsp_valid[0], 1'b0);
      check("rst_run_alu_en", alu_en[0], 1'b0);
      check("rst_run_req_ready", req_ready[0], 1'b1);
      check("rst_run_result", result_o[0], 32'h0);
      rst = 1'b0;
      @(negedge clk);
      req_valid[0] = 1'b0;
      check("restart_cnt0", alu_cnt0[0], 1'b1);
      check("restart_en", alu_en[0], 1'b1);
      n = 1;
      while (!rsp_valid[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("restart_latency", n, 33);
      check("restart_result", result_o[0], 32'd12);
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      check("restart_rsp_clear", rsp_valid[0], 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
